// File: rtl/snoopy_bus_arbiter_if.sv
// ============================================================================
// snoopy_bus_arbiter_if : request/grant, snoop broadcast and reply signals
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface snoopy_bus_arbiter_if #(
   parameter int MAX_NUM_PROCS = 2,
   parameter int KEY_WIDTH     = 32
) ();
   logic [MAX_NUM_PROCS-1:0]           bus_request;
   logic [MAX_NUM_PROCS-1:0]           bus_release;
   logic [MAX_NUM_PROCS-1:0]           bus_grant;
   logic [MAX_NUM_PROCS-1:0]           snoop_check_req;
   logic [MAX_NUM_PROCS*KEY_WIDTH-1:0] proc_key;
   logic                               snoop_check;
   logic [KEY_WIDTH-1:0]               snoop_bus;
   logic [MAX_NUM_PROCS-1:0]           conflict_from_snooper;
   logic [MAX_NUM_PROCS-1:0]           snoop_done;
   logic [MAX_NUM_PROCS-1:0]           conflict_to_proc;

   // Arbiter side
   modport master (
      input  bus_request, bus_release, snoop_check_req, proc_key, conflict_from_snooper,
      output bus_grant, snoop_check, snoop_bus, snoop_done, conflict_to_proc
   );

   // Processor / snooper side
   modport slave (
      output bus_request, bus_release, snoop_check_req, proc_key, conflict_from_snooper,
      input  bus_grant, snoop_check, snoop_bus, snoop_done, conflict_to_proc
   );
endinterface

`default_nettype wire

// File: rtl/snoopy_bus_arbiter.sv
// ============================================================================
// snoopy_bus_arbiter : round-robin bus owner selection, key broadcast and
//                      collection of snooper conflict replies
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module snoopy_bus_arbiter #(
   parameter int MAX_NUM_PROCS = 2,
   parameter int KEY_WIDTH     = 32,
   parameter int SNOOP_LAT     = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   snoopy_bus_arbiter_if.master bus
);
   localparam int IDX_W = (MAX_NUM_PROCS > 1) ? $clog2(MAX_NUM_PROCS) : 1;
   localparam int CNT_W = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWNED = 2'd1,
      SNOOP = 2'd2,
      REPLY = 2'd3
   } state_t;

   state_t                   r_state, w_state;
   logic [IDX_W-1:0]         r_owner, w_owner;
   logic [IDX_W-1:0]         r_rr_ptr, w_rr_ptr;
   logic [CNT_W-1:0]         r_cnt, w_cnt;
   logic                     r_acc, w_acc;
   logic [MAX_NUM_PROCS-1:0] r_grant, w_grant;
   logic                     r_snoop_check, w_snoop_check;
   logic [KEY_WIDTH-1:0]     r_snoop_bus, w_snoop_bus;
   logic [MAX_NUM_PROCS-1:0] r_done, w_done;
   logic [MAX_NUM_PROCS-1:0] r_conf, w_conf;

   logic                     w_found_lo, w_found_hi;
   logic [IDX_W-1:0]         w_win_lo, w_win_hi, w_winner;
   logic [MAX_NUM_PROCS-1:0] w_owner_1h;
   logic [IDX_W-1:0]         w_next_ptr;
   logic                     w_rel, w_sreq, w_hit, w_acc_s;

   // Round-robin pick: first requester at/after the pointer, else lowest index
   always_comb begin
      w_found_lo = 1'b0;
      w_found_hi = 1'b0;
      w_win_lo   = '0;
      w_win_hi   = '0;
      for (int i = 0; i < MAX_NUM_PROCS; i++) begin
         if (bus.bus_request[i] && !w_found_lo) begin
            w_found_lo = 1'b1;
            w_win_lo   = IDX_W'(i);
         end
         if (bus.bus_request[i] && (IDX_W'(i) >= r_rr_ptr) && !w_found_hi) begin
            w_found_hi = 1'b1;
            w_win_hi   = IDX_W'(i);
         end
      end
      w_winner = w_found_hi ? w_win_hi : w_win_lo;
   end

   assign w_owner_1h = {{(MAX_NUM_PROCS-1){1'b0}}, 1'b1} << r_owner;
   assign w_next_ptr = (r_owner == IDX_W'(MAX_NUM_PROCS-1)) ? '0 : r_owner + 1'b1;
   assign w_rel      = bus.bus_release[r_owner];
   assign w_sreq     = bus.snoop_check_req[r_owner];
   assign w_hit      = |(bus.conflict_from_snooper & ~w_owner_1h);
   // The snoop_check cycle itself (count 0) is outside the response window
   assign w_acc_s    = r_acc | ((r_cnt != '0) && w_hit);

   always_comb begin
      w_state       = r_state;
      w_owner       = r_owner;
      w_rr_ptr      = r_rr_ptr;
      w_cnt         = r_cnt;
      w_acc         = r_acc;
      w_grant       = r_grant;
      w_snoop_check = 1'b0;
      w_snoop_bus   = r_snoop_bus;
      w_done        = '0;
      w_conf        = '0;
      case (r_state)
         IDLE: begin
            if (w_found_lo) begin
               w_owner = w_winner;
               w_grant = {{(MAX_NUM_PROCS-1){1'b0}}, 1'b1} << w_winner;
               w_state = OWNED;
            end
         end
         OWNED: begin
            if (w_rel) begin
               w_grant  = '0;
               w_rr_ptr = w_next_ptr;
               w_state  = IDLE;
            end else if (w_sreq) begin
               w_snoop_bus   = bus.proc_key[int'(r_owner)*KEY_WIDTH +: KEY_WIDTH];
               w_snoop_check = 1'b1;
               w_cnt         = '0;
               w_acc         = 1'b0;
               w_state       = SNOOP;
            end
         end
         SNOOP: begin
            if (w_rel) begin
               w_grant  = '0;
               w_rr_ptr = w_next_ptr;
               w_acc    = 1'b0;
               w_state  = IDLE;
            end else if (r_cnt == CNT_W'(SNOOP_LAT)) begin
               w_done  = w_owner_1h;
               w_conf  = w_acc_s ? w_owner_1h : '0;
               w_acc   = 1'b0;
               w_state = REPLY;
            end else begin
               w_acc = w_acc_s;
               w_cnt = r_cnt + 1'b1;
            end
         end
         REPLY: begin
            if (w_rel) begin
               w_grant  = '0;
               w_rr_ptr = w_next_ptr;
               w_state  = IDLE;
            end else begin
               w_state = OWNED;
            end
         end
         default: w_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state       <= IDLE;
         r_owner       <= '0;
         r_rr_ptr      <= '0;
         r_cnt         <= '0;
         r_acc         <= 1'b0;
         r_grant       <= '0;
         r_snoop_check <= 1'b0;
         r_snoop_bus   <= '0;
         r_done        <= '0;
         r_conf        <= '0;
      end else begin
         r_state       <= w_state;
         r_owner       <= w_owner;
         r_rr_ptr      <= w_rr_ptr;
         r_cnt         <= w_cnt;
         r_acc         <= w_acc;
         r_grant       <= w_grant;
         r_snoop_check <= w_snoop_check;
         r_snoop_bus   <= w_snoop_bus;
         r_done        <= w_done;
         r_conf        <= w_conf;
      end
   end

   assign bus.bus_grant        = r_grant;
   assign bus.snoop_check      = r_snoop_check;
   assign bus.snoop_bus        = r_snoop_bus;
   assign bus.snoop_done       = r_done;
   assign bus.conflict_to_proc = r_conf;
endmodule

`default_nettype wire

// File: tb/tb_snoopy_bus_arbiter.sv
// ============================================================================
// tb_snoopy_bus_arbiter : directed stimulus with a queue-based scoreboard
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_snoopy_bus_arbiter;
   localparam int N   = 4;
   localparam int KW  = 32;
   localparam int LAT = 2;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   snoopy_bus_arbiter_if #(.MAX_NUM_PROCS(N), .KEY_WIDTH(KW)) bif ();

   snoopy_bus_arbiter #(.MAX_NUM_PROCS(N), .KEY_WIDTH(KW), .SNOOP_LAT(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif)
   );

   typedef struct {
      logic [N-1:0]  val;
      logic [N-1:0]  aux;
      logic [KW-1:0] key;
      int            cyc;
   } exp_t;

   exp_t q_grant[$];
   exp_t q_key[$];
   exp_t q_done[$];

   int           cyc    = 0;
   int           checks = 0;
   int           passes = 0;
   logic         mon_en = 1'b0;
   logic [N-1:0] prev_grant = '0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t mk(input logic [N-1:0] v, input logic [N-1:0] a,
                               input logic [KW-1:0] k, input int c);
      exp_t e;
      e.val = v; e.aux = a; e.key = k; e.cyc = c;
      return e;
   endfunction

   function automatic logic [N-1:0] oh(input int p);
      logic [N-1:0] r;
      r    = '0;
      r[p] = 1'b1;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [KW-1:0] got, input logic [KW-1:0] want);
      checks++;
      if (got === want) passes++;
      else $display("FAIL %s: got %h, required %h", name, got, want);
   endtask

   // Monitor: every visible DUT event pops and compares the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (bif.bus_grant !== prev_grant) begin
            checks++;
            if (q_grant.size() == 0) begin
               $display("FAIL grant_unexpected: got %b at cycle %0d, required no change", bif.bus_grant, cyc);
            end else begin
               e = q_grant.pop_front();
               if (bif.bus_grant === e.val && cyc == e.cyc && $onehot0(bif.bus_grant)) passes++;
               else $display("FAIL grant: got %b at cycle %0d, required %b at cycle %0d",
                             bif.bus_grant, cyc, e.val, e.cyc);
            end
            prev_grant = bif.bus_grant;
         end
         if (bif.snoop_check !== 1'b0) begin
            checks++;
            if (q_key.size() == 0) begin
               $display("FAIL snoop_check_unexpected: got strobe key %h at cycle %0d, required none", bif.snoop_bus, cyc);
            end else begin
               e = q_key.pop_front();
               if (bif.snoop_check === 1'b1 && bif.snoop_bus === e.key && cyc == e.cyc) passes++;
               else $display("FAIL snoop_check: got key %h at cycle %0d, required %h at cycle %0d",
                             bif.snoop_bus, cyc, e.key, e.cyc);
            end
         end
         if (bif.snoop_done !== '0) begin
            checks++;
            if (q_done.size() == 0) begin
               $display("FAIL done_unexpected: got done %b at cycle %0d, required none", bif.snoop_done, cyc);
            end else begin
               e = q_done.pop_front();
               if (bif.snoop_done === e.val && bif.conflict_to_proc === e.aux && cyc == e.cyc) passes++;
               else $display("FAIL snoop_done: got done %b conf %b at cycle %0d, required done %b conf %b at cycle %0d",
                             bif.snoop_done, bif.conflict_to_proc, cyc, e.val, e.aux, e.cyc);
            end
         end
      end
   end

   task automatic req_grant(input logic [N-1:0] req, input int winner);
      bif.bus_request = req;
      q_grant.push_back(mk(oh(winner), '0, '0, cyc + 1));
      tick();
   endtask

   task automatic release_bus(input int p);
      bif.bus_release    = oh(p);
      bif.bus_request[p] = 1'b0;
      q_grant.push_back(mk('0, '0, '0, cyc + 1));
      tick();
      bif.bus_release = '0;
      tick();
   endtask

   // c0: snoop_check cycle (outside window); c1/c2: the two window cycles
   task automatic snoop(input int p, input logic [KW-1:0] key, input logic [N-1:0] c0,
                        input logic [N-1:0] c1, input logic [N-1:0] c2, input logic exp_conf);
      bif.proc_key[p*KW +: KW] = key;
      bif.snoop_check_req      = oh(p);
      q_key.push_back(mk('0, '0, key, cyc + 1));
      q_done.push_back(mk(oh(p), exp_conf ? oh(p) : '0, '0, cyc + 2 + LAT));
      tick();
      bif.snoop_check_req       = '0;
      bif.conflict_from_snooper = c0;
      tick();
      bif.conflict_from_snooper = c1;
      tick();
      bif.conflict_from_snooper = c2;
      tick();
      bif.conflict_from_snooper = '0;
      tick();
      tick();
   endtask

   initial begin
      int g;
      int w;
      bif.bus_request           = '0;
      bif.bus_release           = '0;
      bif.snoop_check_req       = '0;
      bif.proc_key              = '0;
      bif.conflict_from_snooper = '0;
      repeat (3) tick();
      check("reset_grant",       KW'(bif.bus_grant),        '0);
      check("reset_snoop_check", KW'(bif.snoop_check),      '0);
      check("reset_snoop_bus",   bif.snoop_bus,             '0);
      check("reset_done",        KW'(bif.snoop_done),       '0);
      check("reset_conf",        KW'(bif.conflict_to_proc), '0);
      reset = 1'b1;
      tick();
      mon_en = 1'b1;

      // Round robin: all request, each owner releases 3 cycles after its grant
      bif.bus_request = '1;
      q_grant.push_back(mk(oh(0), '0, '0, cyc + 1));
      g = cyc + 1;
      for (int i = 0; i < 5; i++) begin
         w = i % N;
         while (cyc < g + 3) tick();
         bif.bus_release = oh(w);
         q_grant.push_back(mk('0, '0, '0, g + 4));
         if (i < 4) q_grant.push_back(mk(oh((w + 1) % N), '0, '0, g + 5));
         else       bif.bus_request = '0;
         tick();
         bif.bus_release = '0;
         g = g + 5;
      end
      tick();

      // Single requester 0 with pointer at 1 (wraparound), no conflicts
      req_grant(4'b0001, 0);
      snoop(0, 32'h0000_1234, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      release_bus(0);

      // Conflict paths, owner 2
      req_grant(4'b0100, 2);
      snoop(2, 32'hCAFE_0002, 4'b0000, 4'b0000, 4'b0010, 1'b1);
      snoop(2, 32'hCAFE_0012, 4'b0000, 4'b0100, 4'b0100, 1'b0);
      snoop(2, 32'hCAFE_0022, 4'b1011, 4'b0000, 4'b0000, 1'b0);
      snoop(2, 32'hCAFE_0032, 4'b0000, 4'b1000, 4'b0000, 1'b1);

      // Release and snoop request together: release wins
      bif.bus_release     = oh(2);
      bif.snoop_check_req = oh(2);
      bif.bus_request     = '0;
      q_grant.push_back(mk('0, '0, '0, cyc + 1));
      tick();
      bif.bus_release     = '0;
      bif.snoop_check_req = '0;
      repeat (2) tick();

      // Abort in first SNOOP cycle, then the waiting requester 0 is served
      req_grant(4'b1001, 3);
      bif.proc_key[3*KW +: KW] = 32'hABCD_0003;
      bif.snoop_check_req      = oh(3);
      q_key.push_back(mk('0, '0, 32'hABCD_0003, cyc + 1));
      tick();
      bif.snoop_check_req = '0;
      bif.bus_release     = oh(3);
      bif.bus_request     = 4'b0001;
      q_grant.push_back(mk('0, '0, '0, cyc + 1));
      q_grant.push_back(mk(oh(0), '0, '0, cyc + 2));
      tick();
      bif.bus_release = '0;
      repeat (5) tick();
      release_bus(0);

      // Reset during SNOOP; afterwards pointer restarts at 0
      req_grant(4'b0010, 1);
      bif.proc_key[1*KW +: KW] = 32'hDEAD_0001;
      bif.snoop_check_req      = oh(1);
      q_key.push_back(mk('0, '0, 32'hDEAD_0001, cyc + 1));
      tick();
      bif.snoop_check_req = '0;
      tick();
      reset           = 1'b0;
      bif.bus_request = 4'b0101;
      q_grant.push_back(mk('0, '0, '0, cyc + 1));
      tick();
      reset = 1'b1;
      check("midsnoop_reset_snoop_bus", bif.snoop_bus, '0);
      check("midsnoop_reset_conf", KW'(bif.conflict_to_proc), '0);
      q_grant.push_back(mk(oh(0), '0, '0, cyc + 1));
      tick();
      repeat (4) tick();
      bif.bus_request = '0;
      release_bus(0);

      repeat (4) tick();
      check("grant_queue_drained", KW'(q_grant.size()), '0);
      check("key_queue_drained",   KW'(q_key.size()),   '0);
      check("done_queue_drained",  KW'(q_done.size()),  '0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of stimulus, required finish before time limit");
      $fatal(1, "watchdog expired");
   end
endmodule

`default_nettype wire
